// File: rtl/mem_lsu_if.sv
// CPU data-side request/response bundle plus the attached bram port signals.
// Signal names keep the LSU's point of view: i_* flow into the unit, o_* flow out.
interface mem_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write;
  logic [1:0]            i_req_size;
  logic                  i_req_signed;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [31:0]           i_req_wdata;
  logic                  o_resp_valid;
  logic [31:0]           o_resp_rdata;
  logic                  o_resp_err;
  logic [ADDR_WIDTH-3:0] o_bram_addr;
  logic [31:0]           o_bram_data;
  logic                  o_bram_write;
  logic [31:0]           i_bram_data;

  // LSU side
  modport slave (
    input  i_req_valid, i_req_write, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
    input  i_bram_data,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
    output o_bram_addr, o_bram_data, o_bram_write
  );

  // CPU and bram side
  modport master (
    output i_req_valid, i_req_write, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
    output i_bram_data,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
    input  o_bram_addr, o_bram_data, o_bram_write
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: byte-addressed byte/half/word requests onto a 32-bit word-addressed
// bram port with registered read. Sub-word stores use read-modify-write.
module mem_lsu #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic     i_clk,
  input logic     i_rst,
  mem_lsu_if.slave bus
);

  localparam int unsigned WordWidth = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {StIdle, StRd, StLd, StMrg, StWr, StResp} state_e;

  state_e                state_q, state_d;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;   // store data at accept, merged word after MRG
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic        accept;
  logic        req_bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign accept = bus.i_req_valid && (state_q == StIdle);

  // Alignment and size legality of the incoming request.
  always_comb begin
    req_bad = 1'b0;
    unique case (bus.i_req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = bus.i_req_addr[0];
      2'b10:   req_bad = |bus.i_req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Lane extraction/extension for loads and lane replacement for sub-word stores.
  always_comb begin
    lane_byte = bus.i_bram_data[{addr_q[1:0], 3'b000} +: 8];
    lane_half = bus.i_bram_data[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   ld_ext = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   ld_ext = {{16{signed_q & lane_half[15]}}, lane_half};
      default: ld_ext = bus.i_bram_data;
    endcase
    merged = bus.i_bram_data;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end
  end

  // Next-state sequencing through the access phases.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_bad) begin
            state_d = StResp;
          end else if (bus.i_req_write && bus.i_req_size == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = write_q ? StMrg : StLd;
      StLd:    state_d = StResp;
      StMrg:   state_d = StWr;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, request latches and held response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= bus.i_req_write;
        size_q   <= bus.i_req_size;
        signed_q <= bus.i_req_signed;
        addr_q   <= bus.i_req_addr;
        data_q   <= bus.i_req_wdata;
      end
      if (state_q == StMrg) begin
        data_q <= merged;
      end
      // Response fields change only on entry to RESP so they hold between pulses.
      if (accept && req_bad) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (state_q == StLd) begin
        rdata_q <= ld_ext;
        err_q   <= 1'b0;
      end else if (state_q == StWr) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.o_req_ready  = (state_q == StIdle);
  assign bus.o_resp_valid = (state_q == StResp);
  assign bus.o_resp_rdata = rdata_q;
  assign bus.o_resp_err   = err_q;
  assign bus.o_bram_addr  = addr_q[ADDR_WIDTH-1:2];
  assign bus.o_bram_data  = data_q;
  assign bus.o_bram_write = (state_q == StWr);

  logic [WordWidth-1:0] unused_width_check;
  assign unused_width_check = bus.o_bram_addr;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: bram model with registered write-first read, byte-array reference.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_WIDTH(16)) bus ();

  mem_lsu #(.ADDR_WIDTH(16)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // bram port model
  bit   [31:0] bram_mem [0:16383];
  logic [31:0] bram_q;
  logic [13:0] last_wr_addr;
  int          wr_count;
  always @(posedge clk) begin
    if (bus.o_bram_write) begin
      bram_mem[bus.o_bram_addr] <= bus.o_bram_data;
      last_wr_addr <= bus.o_bram_addr;
      wr_count <= wr_count + 1;
    end
    bram_q <= bus.o_bram_write ? bus.o_bram_data : bram_mem[bus.o_bram_addr];
  end
  assign bus.i_bram_data = bram_q;

  // reference: plain byte-addressed memory
  bit [7:0] ref_b [0:65535];

  int compared;
  int mismatched;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] size, input logic [15:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return addr % 2 != 0;
    if (size == 2'd2) return addr % 4 != 0;
    return 1'b0;
  endfunction

  function automatic int ref_lat(input bit w, input logic [1:0] size, input bit err);
    if (err) return 1;
    if (!w) return 3;
    return (size == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit sgn,
                                           input logic [15:0] addr);
    int n = 1 << size;
    logic [31:0] v = 0;
    logic [31:0] mask;
    bit msb;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(addr) + i]) << (8 * i));
    if (n < 4) begin
      mask = (n == 1) ? 32'h0000_00ff : 32'h0000_ffff;
      msb  = (n == 1) ? v[7] : v[15];
      if (sgn && msb) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_b[4*widx+3], ref_b[4*widx+2], ref_b[4*widx+1], ref_b[4*widx]};
  endfunction

  task automatic do_req(input bit w, input logic [1:0] size, input bit sgn,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    bus.i_req_write  = w;
    bus.i_req_size   = size;
    bus.i_req_signed = sgn;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wdata;
    bus.i_req_valid  = 1'b1;
    for (int k = 0; k < 20 && !bus.o_req_ready; k++) @(negedge clk);
    check("ready_wait", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    lat = -1;
    rdata = 'x;
    err = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.o_resp_valid) begin
        lat = c;
        rdata = bus.o_resp_rdata;
        err = bus.o_resp_err;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input bit w, input logic [1:0] size, input bit sgn,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
    bit          e_err = ref_err(size, addr);
    int          e_lat = ref_lat(w, size, e_err);
    logic [31:0] e_rd  = (!w && !e_err) ? ref_load(size, sgn, addr) : 32'd0;
    int          wc0   = wr_count;
    int          e_wc  = (w && !e_err) ? 1 : 0;
    logic        err;
    int          lat;
    do_req(w, size, sgn, addr, wdata, got, err, lat);
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_rdata"}, got, e_rd);
    check({tag, "_writes"}, 32'(wr_count - wc0), 32'(e_wc));
    if (w && !e_err) begin
      for (int i = 0; i < (1 << size); i++) ref_b[int'(addr) + i] = wdata[8*i +: 8];
    end
    check({tag, "_mem"}, bram_mem[addr[15:2]], ref_word(int'(addr[15:2])));
  endtask

  logic [31:0] got;
  logic [1:0]  b_size [3];
  bit          b_sgn  [3];
  logic [15:0] b_addr [3];
  logic [31:0] b_exp  [3];
  int          acc_t  [3];
  int          na, nr, resp_seen, wc0;
  bit          just;

  initial begin
    rst = 1'b1;
    bus.i_req_valid  = 1'b0;
    bus.i_req_write  = 1'b0;
    bus.i_req_size   = 2'b00;
    bus.i_req_signed = 1'b0;
    bus.i_req_addr   = '0;
    bus.i_req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_resp_valid", 32'(bus.o_resp_valid), 32'd0);
    check("rst_resp_rdata", bus.o_resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.o_resp_err), 32'd0);
    check("rst_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_write", 32'(bus.o_bram_write), 32'd0);

    // word store then load
    run_op("st_w", 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF, got);
    check("st_w_bram_addr", 32'(last_wr_addr), 32'h0004);
    run_op("ld_w", 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, got);
    check("ld_w_const", got, 32'hDEAD_BEEF);

    // byte store and byte loads
    run_op("st_w2", 1'b1, 2'd2, 1'b0, 16'h0010, 32'h1122_3344, got);
    run_op("st_b", 1'b1, 2'd0, 1'b0, 16'h0012, 32'hFFFF_FF80, got);
    check("st_b_const", bram_mem[4], 32'h1180_3344);
    run_op("ld_bs", 1'b0, 2'd0, 1'b1, 16'h0012, 32'h0, got);
    check("ld_bs_const", got, 32'hFFFF_FF80);
    run_op("ld_bu", 1'b0, 2'd0, 1'b0, 16'h0012, 32'h0, got);
    check("ld_bu_const", got, 32'h0000_0080);

    // half store and half loads
    run_op("st_w3", 1'b1, 2'd2, 1'b0, 16'h0010, 32'h1122_3344, got);
    run_op("st_h", 1'b1, 2'd1, 1'b0, 16'h0012, 32'h0000_ABCD, got);
    check("st_h_const", bram_mem[4], 32'hABCD_3344);
    run_op("ld_hs", 1'b0, 2'd1, 1'b1, 16'h0012, 32'h0, got);
    check("ld_hs_const", got, 32'hFFFF_ABCD);
    run_op("ld_hu", 1'b0, 2'd1, 1'b0, 16'h0010, 32'h0, got);
    check("ld_hu_const", got, 32'h0000_3344);

    // misaligned and illegal
    run_op("mis_w", 1'b0, 2'd2, 1'b0, 16'h0011, 32'h0, got);
    run_op("mis_h", 1'b1, 2'd1, 1'b0, 16'h0013, 32'h1234_5678, got);
    check("mis_h_mem", bram_mem[4], 32'hABCD_3344);
    run_op("ill_sz", 1'b1, 2'd3, 1'b0, 16'h0010, 32'h1234_5678, got);
    check("err_held", 32'(bus.o_resp_err), 32'd1);

    // reset in the MRG cycle of a byte store
    run_op("st_w4", 1'b1, 2'd2, 1'b0, 16'h0030, 32'h5566_7788, got);
    run_op("mis_pre", 1'b0, 2'd2, 1'b0, 16'h0032, 32'h0, got);
    wc0 = wr_count;
    @(negedge clk);
    bus.i_req_write = 1'b1; bus.i_req_size = 2'd0; bus.i_req_signed = 1'b0;
    bus.i_req_addr = 16'h0031; bus.i_req_wdata = 32'h0000_00AA; bus.i_req_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rmw_no_wr_in_mrg", 32'(bus.o_bram_write), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmw_rst_err", 32'(bus.o_resp_err), 32'd0);
    check("rmw_rst_rdata", bus.o_resp_rdata, 32'd0);
    @(negedge clk);
    check("rmw_ready_after", 32'(bus.o_req_ready), 32'd1);
    resp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.o_resp_valid) resp_seen++;
      @(negedge clk);
    end
    check("rmw_no_resp", 32'(resp_seen), 32'd0);
    check("rmw_no_write", 32'(wr_count - wc0), 32'd0);
    check("rmw_mem", bram_mem[12], 32'h5566_7788);

    // back-to-back loads with valid held
    run_op("bb_st0", 1'b1, 2'd2, 1'b0, 16'h0020, $urandom, got);
    run_op("bb_st1", 1'b1, 2'd2, 1'b0, 16'h0024, $urandom, got);
    run_op("bb_st2", 1'b1, 2'd2, 1'b0, 16'h0028, $urandom, got);
    b_size[0] = 2'd0; b_sgn[0] = 1'b1; b_addr[0] = 16'h0021;
    b_size[1] = 2'd1; b_sgn[1] = 1'b0; b_addr[1] = 16'h0026;
    b_size[2] = 2'd2; b_sgn[2] = 1'b1; b_addr[2] = 16'h0028;
    for (int i = 0; i < 3; i++) b_exp[i] = ref_load(b_size[i], b_sgn[i], b_addr[i]);
    na = 0; nr = 0; just = 1'b0;
    @(negedge clk);
    bus.i_req_write = 1'b0; bus.i_req_size = b_size[0]; bus.i_req_signed = b_sgn[0];
    bus.i_req_addr = b_addr[0]; bus.i_req_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (just) begin
        check("bb_ready_low", 32'(bus.o_req_ready), 32'd0);
        just = 1'b0;
        if (na < 3) begin
          bus.i_req_size = b_size[na]; bus.i_req_signed = b_sgn[na]; bus.i_req_addr = b_addr[na];
        end else begin
          bus.i_req_valid = 1'b0;
        end
      end
      if (bus.o_resp_valid) begin
        if (nr < 3) check("bb_rdata", bus.o_resp_rdata, b_exp[nr]);
        nr++;
      end
      if (bus.i_req_valid && bus.o_req_ready && na < 3) begin
        acc_t[na] = t;
        na++;
        just = 1'b1;
      end
      @(negedge clk);
    end
    check("bb_accepts", 32'(na), 32'd3);
    check("bb_resps", 32'(nr), 32'd3);
    check("bb_space01", 32'(acc_t[1] - acc_t[0]), 32'd4);
    check("bb_space12", 32'(acc_t[2] - acc_t[1]), 32'd4);

    // randomized mix against the byte-array reference
    for (int i = 0; i < 80; i++) begin
      run_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), $urandom, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
